// File: rtl/byte_unstriping.sv
// Merges two 2f-rate byte lanes into one serial byte stream through a small pair FIFO.
// Optional skew-error counter port err_count when BYTE_UNSTRIPING_ERRCNT_EN is defined.
//
// state | meaning
// IDLE  | no pending byte; pops the next lane pair when dout_ready
// SEND1 | lane1 byte of the last popped pair still to be emitted
module byte_unstriping #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk2f,
    input  logic       reset_L,
    input  logic [8:0] lane0,
    input  logic [8:0] lane1,
    input  logic       dout_ready,
    output logic [8:0] dataout,
    output logic       fifo_full,
    output logic       overflow
`ifdef BYTE_UNSTRIPING_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SEND1 = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          phase_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [7:0]    pend_q, pend_d;
    logic [8:0]    dataout_q, dataout_d;
    logic          full_q;
    logic          ovf_q, ovf_d;

    logic          sample;
    logic          push_req;
    logic          skew;
    logic          fifo_empty;
    logic          is_full;
    logic          pop;
    logic          push;
    logic [16:0]   rd_entry;

    // Lanes are only stable on the phase-0 edge of each 2f pair
    assign sample     = ~phase_q;
    assign push_req   = sample & lane0[8];
    assign skew       = sample & ~lane0[8] & lane1[8];
    assign fifo_empty = (count_q == '0);
    assign is_full    = (count_q == DEPTH_C);
    assign pop        = dout_ready & (state_q == ST_IDLE) & ~fifo_empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the pair
    assign push       = push_req & (~is_full | pop);
    assign rd_entry   = mem_q[rd_ptr_q];

    always_ff @(posedge clk2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            dataout_q <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= ~phase_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            dataout_q <= dataout_d;
            full_q    <= (count_d == DEPTH_C);
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk2f) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lane1[8], lane1[7:0], lane0[7:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        if (dout_ready) begin
            case (state_q)
                ST_IDLE:  if (pop && rd_entry[16]) state_d = ST_SEND1;
                ST_SEND1: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dataout_d = dataout_q;
        pend_d    = pend_q;
        if (dout_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        dataout_d = {1'b1, rd_entry[7:0]};
                        pend_d    = rd_entry[15:8];
                    end else begin
                        dataout_d = 9'h000;
                    end
                end
                ST_SEND1: dataout_d = {1'b1, pend_q};
                default:  dataout_d = 9'h000;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push_req & is_full & ~pop);
    end

    assign dataout   = dataout_q;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;

`ifdef BYTE_UNSTRIPING_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk2f or negedge reset_L) begin
        if (!reset_L) begin
            err_cnt_q <= '0;
        end else if (skew && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_skew;
    assign unused_skew = skew;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping; checks err_count too when BYTE_UNSTRIPING_ERRCNT_EN is defined.
module tb_byte_unstriping;

    logic       clk2f;
    logic       reset_L;
    logic [8:0] lane0;
    logic [8:0] lane1;
    logic       dout_ready;
    logic [8:0] dataout;
    logic       fifo_full;
    logic       overflow;
`ifdef BYTE_UNSTRIPING_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    byte_unstriping #(.FIFO_DEPTH(4)) dut (
        .clk2f      (clk2f),
        .reset_L    (reset_L),
        .lane0      (lane0),
        .lane1      (lane1),
        .dout_ready (dout_ready),
        .dataout    (dataout),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
`ifdef BYTE_UNSTRIPING_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk2f = 1'b0;
    always #5 clk2f = ~clk2f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk2f);
        #1;
    endtask

    // Leaves the bench just before a phase-0 edge.
    task automatic do_reset(input logic rdy);
        reset_L    = 1'b0;
        lane0      = 9'h000;
        lane1      = 9'h000;
        dout_ready = rdy;
        #2;
        @(negedge clk2f);
        reset_L = 1'b1;
    endtask

    task automatic pair(input logic [8:0] a, input logic [8:0] b);
        lane0 = a;
        lane1 = b;
        step();
        step();
    endtask

    logic [8:0] q033 [8] = '{9'h131, 9'h141, 9'h132, 9'h142,
                             9'h133, 9'h143, 9'h150, 9'h160};

    initial begin
        reset_L    = 1'b0;
        lane0      = 9'h000;
        lane1      = 9'h000;
        dout_ready = 1'b0;
        #3;
        check("rst_dataout", 16'(dataout), 16'h000);
        check("rst_full", 16'(fifo_full), 16'h0);
        check("rst_ovf", 16'(overflow), 16'h0);
`ifdef BYTE_UNSTRIPING_ERRCNT_EN
        check("rst_errcnt", 16'(err_count), 16'h00);
`endif

        // full pair, then drain to idle
        do_reset(1'b1);
        lane0 = 9'h1A5;
        lane1 = 9'h15A;
        step();
        check("p1_e0", 16'(dataout), 16'h000);
        step();
        check("p1_l0", 16'(dataout), 16'h1A5);
        lane0 = 9'h000;
        lane1 = 9'h000;
        step();
        check("p1_l1", 16'(dataout), 16'h15A);
        step();
        check("p1_idle", 16'(dataout), 16'h000);

        // lane1 not valid: only lane0 byte
        lane0 = 9'h111;
        lane1 = 9'h000;
        step();
        check("p2_e0", 16'(dataout), 16'h000);
        step();
        check("p2_l0", 16'(dataout), 16'h111);
        lane0 = 9'h000;
        step();
        check("p2_nol1", 16'(dataout), 16'h000);
        step();
        check("p2_idle", 16'(dataout), 16'h000);

        // skew pair dropped
        lane0 = 9'h000;
        lane1 = 9'h1FF;
        step();
        check("skew_e0", 16'(dataout), 16'h000);
        step();
        check("skew_e1", 16'(dataout), 16'h000);
        lane1 = 9'h000;
        step();
        check("skew_e2", 16'(dataout), 16'h000);
        step();
        check("skew_e3", 16'(dataout), 16'h000);
        check("skew_full", 16'(fifo_full), 16'h0);
`ifdef BYTE_UNSTRIPING_ERRCNT_EN
        check("errcnt_1", 16'(err_count), 16'h01);
        for (int i = 0; i < 299; i++) pair(9'h000, 9'h1FF);
        lane1 = 9'h000;
        check("errcnt_sat", 16'(err_count), 16'h0FF);
        check("skew_many_out", 16'(dataout), 16'h000);
`endif

        // fill with dout_ready low, overflow on 5th pair, then drain
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            pair({1'b1, 8'h10 + 8'(k)}, {1'b1, 8'h20 + 8'(k)});
            if (k == 2) check("ovf_full_k2", 16'(fifo_full), 16'h0);
            if (k == 3) begin
                check("ovf_full_k3", 16'(fifo_full), 16'h1);
                check("ovf_ovf_k3", 16'(overflow), 16'h0);
            end
        end
        check("ovf_full_k4", 16'(fifo_full), 16'h1);
        check("ovf_ovf_k4", 16'(overflow), 16'h1);
        check("ovf_hold_out", 16'(dataout), 16'h000);
        lane0 = 9'h000;
        lane1 = 9'h000;
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i % 2 == 0)
                check("ovf_drain_l0", 16'(dataout), 16'({1'b1, 8'h10 + 8'(i / 2)}));
            else
                check("ovf_drain_l1", 16'(dataout), 16'({1'b1, 8'h20 + 8'(i / 2)}));
            if (i == 0) check("ovf_full_pop", 16'(fifo_full), 16'h0);
        end
        step();
        check("ovf_drain_end", 16'(dataout), 16'h000);
        check("ovf_sticky", 16'(overflow), 16'h1);

        // full FIFO, push on the pop edge
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) pair({1'b1, 8'h30 + 8'(k)}, {1'b1, 8'h40 + 8'(k)});
        check("pp_full_pre", 16'(fifo_full), 16'h1);
        lane0 = 9'h150;
        lane1 = 9'h160;
        dout_ready = 1'b1;
        step();
        check("pp_out0", 16'(dataout), 16'h130);
        check("pp_full", 16'(fifo_full), 16'h1);
        check("pp_ovf", 16'(overflow), 16'h0);
        step();
        check("pp_out1", 16'(dataout), 16'h140);
        lane0 = 9'h000;
        lane1 = 9'h000;
        for (int i = 0; i < 8; i++) begin
            step();
            check("pp_drain", 16'(dataout), 16'(q033[i]));
        end
        step();
        check("pp_end", 16'(dataout), 16'h000);
        check("pp_ovf_end", 16'(overflow), 16'h0);
        check("pp_full_end", 16'(fifo_full), 16'h0);

        // async reset while in SEND1 with two entries queued
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) pair({1'b1, 8'h70 + 8'(k)}, {1'b1, 8'h80 + 8'(k)});
        lane0 = 9'h000;
        lane1 = 9'h000;
        dout_ready = 1'b1;
        step();
        check("ar_pre", 16'(dataout), 16'h170);
        #2;
        reset_L = 1'b0;
        #1;
        check("ar_dataout", 16'(dataout), 16'h000);
        check("ar_full", 16'(fifo_full), 16'h0);
        check("ar_ovf", 16'(overflow), 16'h0);
        @(negedge clk2f);
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_after", 16'(dataout), 16'h000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
